// File: rtl/instr_pkg.sv
// Shared instruction-format definitions.
// Holds the symbolic op enum, the 6-bit opcode/func constants and the bit
// positions of every field in the 32-bit word. The instruction decoder
// imports the same package, so writer and reader always agree on the layout.
package instr_pkg;

  // Symbolic operation selector carried on the loader input.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_LW   = 3'd2,
    OP_SW   = 3'd3,
    OP_BNE  = 3'd4,
    OP_J    = 3'd5,
    OP_JAL  = 3'd6,
    OP_XORI = 3'd7
  } op_e;

  // Opcode and function-code values.
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;

  // Field LSB positions inside the 32-bit word.
  localparam int OPC_LSB   = 0;
  localparam int RS_LSB    = 6;
  localparam int RT_LSB    = 11;
  localparam int RD_LSB    = 16;
  localparam int SHAMT_LSB = 21;
  localparam int FUNC_LSB  = 26;
  localparam int IMM_LSB   = 16;
  localparam int TGT_LSB   = 6;

  // Loader session FSM states (exposed on the loader's debug port).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational instruction packer: symbolic op + fields -> 32-bit word.
// Ports:
//   i_op      operation selector (op_e)
//   i_rs/i_rt/i_rd/i_shamt  5-bit register / shift fields
//   i_imm16   16-bit immediate (I-type)
//   i_target  26-bit jump target (J-type)
//   o_word    packed instruction word
// Fields that a format does not use are left at zero.
module instr_pack
  import instr_pkg::*;
(
  input  op_e         i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_target,
  output logic [31:0] o_word
);

  always_comb begin
    o_word = '0;
    case (i_op)
      OP_ADD, OP_SUB: begin
        o_word[OPC_LSB +: 6]   = OPC_RTYPE;
        o_word[RS_LSB +: 5]    = i_rs;
        o_word[RT_LSB +: 5]    = i_rt;
        o_word[RD_LSB +: 5]    = i_rd;
        o_word[SHAMT_LSB +: 5] = i_shamt;
        o_word[FUNC_LSB +: 6]  = (i_op == OP_ADD) ? FUNC_ADD : FUNC_SUB;
      end
      OP_LW, OP_SW, OP_BNE, OP_XORI: begin
        // The immediate occupies [31:16], overlapping rd/shamt/func,
        // so rd and shamt are deliberately dropped for I-type.
        case (i_op)
          OP_LW:   o_word[OPC_LSB +: 6] = OPC_LW;
          OP_SW:   o_word[OPC_LSB +: 6] = OPC_SW;
          OP_BNE:  o_word[OPC_LSB +: 6] = OPC_BNE;
          default: o_word[OPC_LSB +: 6] = OPC_XORI;
        endcase
        o_word[RS_LSB +: 5]   = i_rs;
        o_word[RT_LSB +: 5]   = i_rt;
        o_word[IMM_LSB +: 16] = i_imm16;
      end
      OP_J, OP_JAL: begin
        o_word[OPC_LSB +: 6]  = (i_op == OP_J) ? OPC_J : OPC_JAL;
        o_word[TGT_LSB +: 26] = i_target;
      end
      default: o_word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder / imem loader.
// Accepts symbolic instructions over a valid/ready handshake, packs each into
// a 32-bit word and writes the words to consecutive imem addresses.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, base_addr, length     session start pulse, first address, word count
//   in_valid / in_ready          input handshake
//   in_op, in_rs, in_rt, in_rd, in_shamt, in_imm16, in_target  instruction fields
//   imem_we / imem_ready         write handshake
//   imem_addr, imem_wdata        write address / packed word
//   busy, done, count            session status, words written this session
//   err_overrun                  sticky: in_valid seen while DONE
//   dbg_state                    current session FSM state
// Handshake rule (both interfaces): a transfer happens on a rising edge where
// valid and ready are both high; valid-side data must hold while valid is high
// and ready is low. in_ready depends on imem_ready combinationally so that a
// new word can be accepted in the same cycle the held word is written.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm16,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_overrun,
  output load_state_e       dbg_state
);

  localparam logic [ADDR_W:0] L_MAX   = MAX_LEN[ADDR_W:0];
  localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

  load_state_e       r_state;
  load_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic [ADDR_W:0]   w_len_clamp;
  logic              w_start_ok;
  logic              w_write;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_last_accept;
  logic [31:0]       w_packed;

  instr_pack u_pack (
    .i_op     (op_e'(in_op)),
    .i_rs     (in_rs),
    .i_rt     (in_rt),
    .i_rd     (in_rd),
    .i_shamt  (in_shamt),
    .i_imm16  (in_imm16),
    .i_target (in_target),
    .o_word   (w_packed)
  );

  assign w_len_clamp   = (length > L_MAX) ? L_MAX : length;
  // start is only honoured between sessions; mid-session it is dropped.
  assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_write       = r_we && imem_ready;
  assign w_in_ready    = (r_state == ST_LOAD) && (r_remaining != '0) && (!r_we || imem_ready);
  assign w_accept      = in_valid && w_in_ready;
  assign w_last_accept = w_accept && (r_remaining == REM_ONE);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_nxt = (w_len_clamp == '0) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD: begin
        if (w_last_accept) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Only the final word can be outstanding here.
        if (w_write) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Session counters and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else if (w_start_ok) begin
      r_addr      <= base_addr;
      r_remaining <= w_len_clamp;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr      <= r_addr + 1'b1;  // wraps modulo 2**ADDR_W
        r_remaining <= r_remaining - 1'b1;
      end
      if (w_write) r_count <= r_count + 1'b1;
      if ((r_state == ST_DONE) && in_valid) r_err <= 1'b1;
    end
  end

  // Output register: loads on accept, otherwise clears once written, and
  // holds while the memory stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= 1'b1;
      r_waddr <= r_addr;
      r_wdata <= w_packed;
    end else if (w_write) begin
      r_we    <= 1'b0;
    end
  end

  assign in_ready    = w_in_ready;
  assign imem_we     = r_we;
  assign imem_addr   = r_waddr;
  assign imem_wdata  = r_wdata;
  assign busy        = (r_state == ST_LOAD) || r_we;
  assign done        = (r_state == ST_DONE);
  assign count       = r_count;
  assign err_overrun = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  import instr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm16;
  logic [25:0] in_target;
  logic        imem_we;
  logic        imem_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic [8:0]  count;
  logic        err_overrun;
  load_state_e dbg_state;

  instr_encoder_loader #(.ADDR_W(8), .MAX_LEN(256)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_imm16(in_imm16), .in_target(in_target),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .count(count), .err_overrun(err_overrun), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Word layout from the format rules, using plain shifts.
  function automatic logic [31:0] model_pack(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt);
    logic [31:0] r;
    logic [31:0] regs_i;
    regs_i = (32'(rs) << 6) | (32'(rt) << 11) | ((32'(imm) & 32'hFFFF) << 16);
    case (op)
      0: r = (32'h20 << 26) | (32'(sh) << 21) | (32'(rd) << 16) | (32'(rt) << 11) | (32'(rs) << 6);
      1: r = (32'h22 << 26) | (32'(sh) << 21) | (32'(rd) << 16) | (32'(rt) << 11) | (32'(rs) << 6);
      2: r = 32'h23 | regs_i;
      3: r = 32'h2B | regs_i;
      4: r = 32'h05 | regs_i;
      5: r = 32'h02 | ((32'(tgt) & 32'h3FFFFFF) << 6);
      6: r = 32'h03 | ((32'(tgt) & 32'h3FFFFFF) << 6);
      default: r = 32'h0E | regs_i;
    endcase
    return r;
  endfunction

  // Scoreboard: expected {addr, wdata} in write order.
  logic [39:0] exp_q[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          cyc = 0;
  int          total_writes = 0;
  int          sess_base = 0;
  int          stall_cycles = 0;
  int          last_acc_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;

  always @(posedge clk) cyc++;

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    logic [39:0] e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      check("count", 64'(count), 64'(total_writes - sess_base));
      if (prev_stall) begin
        check("hold_we", 64'(imem_we), 64'd1);
        check("hold_addr", 64'(imem_addr), 64'(prev_addr));
        check("hold_data", 64'(imem_wdata), 64'(prev_data));
      end
      if (imem_we && !imem_ready) begin
        check("in_ready_stall", 64'(in_ready), 64'd0);
        stall_cycles++;
      end
      if (imem_we && imem_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("waddr", 64'(imem_addr), 64'(e[39:32]));
          check("wdata", 64'(imem_wdata), 64'(e[31:0]));
        end
        wr_addr_q.push_back(imem_addr);
        wr_data_q.push_back(imem_wdata);
        wr_cyc_q.push_back(cyc);
        total_writes++;
      end
      prev_stall = imem_we && !imem_ready;
      prev_addr  = imem_addr;
      prev_data  = imem_wdata;
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic do_start(input logic [7:0] b, input logic [8:0] len);
    start = 1'b1; base_addr = b; length = len;
    @(posedge clk);
    sess_base = total_writes;
    #1 start = 1'b0;
  endtask

  task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input int tgt, input logic [7:0] a);
    bit got;
    got = 0;
    in_op = 3'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm16 = 16'(imm); in_target = 26'(tgt);
    exp_q.push_back({a, model_pack(op, rs, rt, rd, sh, imm, tgt)});
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    last_acc_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_reached", 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 64'(imem_we), 64'd0);
    check({tag, "_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_err"}, 64'(err_overrun), 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int i0;
    int n0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm16 = '0; in_target = '0;
    imem_ready = 1'b1;
    #2;
    check_reset_outputs("reset");
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // in_valid while IDLE: ignored, no error, no write.
    in_valid = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("idle_no_err", 64'(err_overrun), 64'd0);
    @(posedge clk); #1;

    // len=0 from IDLE: DONE next cycle, nothing written.
    n0 = total_writes;
    do_start(8'h20, 9'd0);
    @(negedge clk);
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_writes", 64'(total_writes), 64'(n0));

    // Scenario 1: single ADD.
    do_start(8'h00, 9'd1);
    send(0, 31, 0, 17, 0, 0, 0, 8'h00);
    idle_in();
    wait_done(20);
    check("s1_latency", 64'(wr_cyc_q[$] - last_acc_cyc), 64'd1);
    check("s1_addr", 64'(wr_addr_q[$]), 64'h00);
    check("s1_word", 64'(wr_data_q[$]), 64'h8011_07C0);
    check("s1_count", 64'(count), 64'd1);

    // Scenario 2: back-to-back mix, full throughput.
    i0 = wr_cyc_q.size();
    do_start(8'h10, 9'd5);
    send(2, 1, 2, 9, 3, 16'hFFFC, 0, 8'h10);
    send(3, 3, 4, 9, 3, 16'h0010, 0, 8'h11);
    send(4, 5, 6, 9, 3, 16'hFFF0, 0, 8'h12);
    send(5, 7, 7, 7, 7, 0, 26'h3FFFFFF, 8'h13);
    send(7, 7, 8, 9, 3, 16'h00FF, 0, 8'h14);
    idle_in();
    wait_done(20);
    check("s2_throughput", 64'(wr_cyc_q[i0 + 4] - wr_cyc_q[i0]), 64'd4);
    check("s2_lw_word", 64'(wr_data_q[i0]), 64'hFFFC_1063);
    check("s2_sw_word", 64'(wr_data_q[i0 + 1]), 64'h0010_20EB);
    check("s2_j_word", 64'(wr_data_q[i0 + 3]), 64'hFFFF_FFC2);
    check("s2_count", 64'(count), 64'd5);

    // Scenario 3: memory stalls 3 cycles on the 2nd word.
    n0 = stall_cycles;
    do_start(8'h40, 9'd3);
    send(0, 1, 2, 3, 4, 0, 0, 8'h40);
    send(1, 5, 6, 7, 8, 0, 0, 8'h41);
    fork
      send(7, 9, 10, 0, 0, 16'h1234, 0, 8'h42);
      begin
        imem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 imem_ready = 1'b1;
      end
    join
    idle_in();
    wait_done(20);
    check("s3_stalls", 64'(stall_cycles - n0), 64'd3);
    check("s3_count", 64'(count), 64'd3);

    // Scenario 4: address wrap.
    i0 = wr_addr_q.size();
    do_start(8'hFE, 9'd4);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a;
      a = 8'hFE + 8'(k);
      send(k % 2, k, k + 1, k + 2, 0, 0, 0, a);
    end
    idle_in();
    wait_done(20);
    check("s4_addr0", 64'(wr_addr_q[i0]), 64'hFE);
    check("s4_addr1", 64'(wr_addr_q[i0 + 1]), 64'hFF);
    check("s4_addr2", 64'(wr_addr_q[i0 + 2]), 64'h00);
    check("s4_addr3", 64'(wr_addr_q[i0 + 3]), 64'h01);

    // Scenario 5: length above MAX_LEN clamps to 256 words.
    do_start(8'h00, 9'd300);
    for (int k = 0; k < 256; k++) begin
      send(k % 8, k % 32, (k * 7) % 32, (k * 3) % 32, (k * 5) % 32,
           (k * 16'h0101) & 16'hFFFF, k * 26'h0012345, 8'(k));
    end
    idle_in();
    wait_done(20);
    check("s5_count", 64'(count), 64'd256);
    check("s5_writes", 64'(total_writes - sess_base), 64'd256);

    // Overrun: in_valid in DONE sets sticky error, next start clears it.
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("s5_err_set", 64'(err_overrun), 64'd1);
    check("s5_err_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    do_start(8'h00, 9'd0);
    @(negedge clk);
    check("s5_err_clear", 64'(err_overrun), 64'd0);
    @(posedge clk); #1;

    // Scenario 6: async reset with a pending, stalled write.
    do_start(8'h80, 9'd4);
    imem_ready = 1'b0;
    send(0, 1, 1, 1, 1, 0, 0, 8'h80);
    idle_in();
    check("s6_pending", 64'(imem_we), 64'd1);
    n0 = total_writes;
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("s6_reset");
    exp_q.delete();
    sess_base = total_writes;
    @(negedge clk);
    reset_n = 1'b1;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    check("s6_abandoned", 64'(total_writes), 64'(n0));
    do_start(8'h00, 9'd1);
    send(0, 31, 0, 17, 0, 0, 0, 8'h00);
    idle_in();
    wait_done(20);
    check("s6_latency", 64'(wr_cyc_q[$] - last_acc_cyc), 64'd1);
    check("s6_word", 64'(wr_data_q[$]), 64'h8011_07C0);
    check("s6_count", 64'(count), 64'd1);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
